// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetch PC, 2-entry {pc, instr} buffer,
// redirect flush and terminal fetch-fault handling.
module ifetch_ctrl #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          IMEM_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        fault,
   output logic [15:0] fault_pc
);

   localparam logic [0:0]  FETCH    = 1'b0;
   localparam logic [0:0]  FAULT    = 1'b1;
   localparam logic [16:0] PC_LIMIT = 17'(2 * IMEM_WORDS);

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ins;
   } fq_t;

   logic [0:0]  state;
   logic [15:0] fpc;
   fq_t         fq [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;

   logic        run;
   logic        pc_ok;
   logic        pop;
   logic        push;
   logic        redir;
   logic        trap;

   assign run   = (state == FETCH);
   assign pc_ok = ~fpc[0] && ({1'b0, fpc} < PC_LIMIT);

   assign instr_valid = run && (count != 2'd0);
   assign pop         = instr_valid && instr_ready;

   // Redirect outranks both a fetch and a fault on the same edge.
   assign redir = run && redirect_valid;
   assign trap  = run && !redirect_valid && !pc_ok;
   assign push  = run && !redirect_valid && pc_ok
                  && ((count != 2'd2) || pop);

   assign imem_addr = fpc;
   assign instr     = fq[rd_ptr].ins;
   assign instr_pc  = fq[rd_ptr].pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         fault    <= 1'b0;
         fault_pc <= 16'h0000;
      end else if (trap) begin
         state    <= FAULT;
         fault    <= 1'b1;
         fault_pc <= fpc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc <= RESET_PC;
      end else if (redir) begin
         fpc <= redirect_pc;
      end else if (push) begin
         fpc <= fpc + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (redir || trap) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push && !pop) begin
            count <= count + 2'd1;
         end else if (pop && !push) begin
            count <= count - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq[0] <= '0;
         fq[1] <= '0;
      end else if (push) begin
         fq[wr_ptr] <= '{pc: fpc, ins: imem_data};
      end
   end

endmodule
